// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Purpose:
//   Receive-side byte buffer that sits directly behind the UART receiver.
//   Each receiver done pulse writes one byte into a circular FIFO. A consumer
//   (the host bus or the TX loopback path) pops bytes from the other side.
//   The block reports fill level and a sticky overrun flag, so a byte dropped
//   because the FIFO was full is never lost silently.
//
// Configuration macro:
//   FIFO_FWFT_EN  defined   -> first-word-fall-through read port
//                 undefined -> registered read port with 1-cycle latency
//                              (default build)
//
// Parameters:
//   DATA_W       width of each stored entry (one UART byte)
//   ADDR_W       log2 of FIFO depth (depth = 2**ADDR_W)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   push         write strobe (receiver done pulse), one entry per high cycle
//   push_data    byte written when push=1
//   pop          read strobe / acknowledge from the consumer
//   pop_data     read data
//   pop_valid    pop_data qualifier
//   empty        FIFO holds no entries
//   full         FIFO holds 2**ADDR_W entries
//   count        current occupancy, 0..2**ADDR_W
//   overrun      sticky, a push was dropped because the FIFO was full
//   overrun_clr  clears overrun (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int DEPTH = 1 << ADDR_W;

    // Pointers carry one extra wrap bit so full and empty can be told apart
    // when the address bits match.
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    logic [DATA_W-1:0] mem [DEPTH];

    logic rd_acc;
    logic wr_acc;
    logic drop;

    assign wr_addr = wr_ptr[ADDR_W-1:0];
    assign rd_addr = rd_ptr[ADDR_W-1:0];

    // Status is derived from registered pointers only; push/pop never reach
    // these outputs combinationally.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_addr == rd_addr) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign count = wr_ptr - rd_ptr;

    // A pop on a full FIFO frees a slot in the same cycle, so a simultaneous
    // push is still accepted and lands in the slot being vacated.
    assign rd_acc = pop && !empty;
    assign wr_acc = push && (!full || rd_acc);
    assign drop   = push && full && !rd_acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is not reset; contents behind rd_ptr are never observed.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_addr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head entry is presented whenever the FIFO is non-empty; pop is an
    // acknowledge that advances to the next word on the following cycle.
    assign pop_data  = empty ? '0 : mem[rd_addr];
    assign pop_valid = !empty;
`else
    // Registered read: data is captured on the accepted pop edge and held
    // until the next accepted pop; pop_valid is a single-cycle pulse.
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= mem[rd_addr];
            end
        end
    end

    assign pop_data  = rd_data_q;
    assign pop_valid = rd_valid_q;
`endif

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer placed directly downstream of the UART receiver. It captures each received byte on the receiver's one-cycle done pulse and stores it in a circular FIFO. A consumer, either the host bus or the TX loopback path, pops bytes from the other side. The block also reports fill level and a sticky overrun flag, so no received byte is lost silently.

Parameters:
DATA_W, 8, width of each stored entry (one UART byte)
ADDR_W, 4, log2 of FIFO depth; depth = 2**ADDR_W = 16 entries

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous active-low reset (0 = reset asserted)
push  input  1  write strobe; connected to receiver done pulse; one entry per high cycle
push_data  input  DATA_W  byte written when push=1
pop  input  1  read strobe from consumer
pop_data  output  DATA_W  read data (timing depends on FIFO_FWFT_EN)
pop_valid  output  1  pop_data qualifier
empty  output  1  FIFO holds 0 entries
full  output  1  FIFO holds 2**ADDR_W entries
count  output  ADDR_W+1  current occupancy, 0..2**ADDR_W
overrun  output  1  sticky; a push was dropped because FIFO was full
overrun_clr  input  1  clears overrun

Behaviour:
- Reset (rst=0, async): rd_ptr=0, wr_ptr=0, count=0, empty=1, full=0, overrun=0, pop_data=0, pop_valid=0. Memory contents are don't-care. Reset asserted mid-transfer discards all entries immediately.
- Pointers: ADDR_W+1 bits each; MSB is the wrap bit. empty = (wr_ptr==rd_ptr). full = (addr bits equal, MSBs differ). count = wr_ptr - rd_ptr, modulo 2**(ADDR_W+1). All are registered-state derived; no combinational path from push/pop.
- Write accepted: push=1 and (full=0, or pop accepted in the same cycle). Writes mem[wr_ptr]=push_data, then wr_ptr+1.
- Read accepted: pop=1 and empty=0. rd_ptr+1.
- Simultaneous accepted push and pop: count unchanged. Allowed when full: the pop frees a slot and the push lands in it. When empty, the pop is ignored and the push is accepted, so count goes 0->1.
- Push when full with no pop: data dropped, pointers unchanged, overrun set on the next edge.
- overrun: set on a dropped push; cleared by overrun_clr=1. If set and clear happen in the same cycle, set wins.
- Pop when empty: ignored; no pointer change, pop_valid stays 0.
- Pointer wrap: 16 pushes from wr_ptr=0 gives wr_ptr=5'b10000, full=1. Ordering is preserved across wrap.
- A push pulse longer than one cycle pushes once per cycle; the upstream receiver guarantees one-cycle pulses.

Optional Feature:
FIFO_FWFT_EN
- Defined (first-word-fall-through): pop_data = mem[rd_ptr] whenever empty=0, and pop_valid = !empty. A word written into an empty FIFO appears on pop_data one cycle after its push edge. pop acts as an acknowledge, and the next word (or invalid) appears the cycle after the pop.
- Undefined (standard read): pop_data is a register loaded from mem[rd_ptr] on the edge of an accepted pop. pop_valid is a one-cycle pulse in the cycle after the accepted pop. pop_data holds its value until the next accepted pop. Read latency is 1 cycle.

Test Plan:
- Reset/idle: hold rst=0 then release -> empty=1, full=0, count=0, overrun=0, pop_valid=0. Pop on empty -> no change, pop_valid=0.
- Ordering: push 0x41,0x42,0x43 on consecutive cycles, then pop 3 times -> pop_data sequence 0x41,0x42,0x43, each with pop_valid. count steps 3->0; empty=1 at end.
- Full/overrun: push 0x00..0x0F (16 pushes) -> full=1, count=16. Push 0xAA -> dropped, overrun=1. Pop all 16 -> 0x00..0x0F, with 0xAA never output. overrun_clr=1 -> overrun=0. Also assert overrun_clr in the same cycle as another dropped push -> overrun stays 1.
- Simultaneous: while full, push 0x55 and pop in the same cycle -> count stays 16, full=1, 0x55 read last. While empty, push 0x66 and pop in the same cycle -> count=1, 0x66 later read.
- Wrap: 3 rounds of push 10 / pop 10 (pointers wrap past 16) -> data matches the scoreboard, with count never above 10 and no overrun.
- Reset mid-operation: with count=5, drive rst=0 for one cycle (async, between edges) -> count=0 and empty=1 immediately. A following push 0x77 then pop returns 0x77. Run this test with FIFO_FWFT_EN both defined and undefined, checking read latency as specified for each.
